// File: rtl/imap_pingpong_buf.sv
// Double-buffered input feature map buffer: the writer fills one region of banks while the
// reader gathers multi-lane words from the other; same-bank lanes are serialised and counted.
module imap_pingpong_buf #(
   parameter int NUM_BANKS  = 8,
   parameter int BANK_DEPTH = 1024,
   parameter int DATA_W     = 64,
   parameter int RD_LANES   = 4,
   parameter int ADDR_W     = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         wr_last,
   input  logic                         rd_req_valid,
   output logic                         rd_req_ready,
   input  logic [RD_LANES*ADDR_W-1:0]   rd_addr,
   input  logic [RD_LANES-1:0]          rd_lane_en,
   output logic                         rd_valid,
   output logic [RD_LANES*DATA_W-1:0]   rd_data,
   input  logic                         rd_release,
   output logic [1:0]                   region_full,
   output logic                         wr_region,
   output logic                         rd_region,
   output logic [15:0]                  conflict_cnt
);

   localparam int HALF = NUM_BANKS / 2;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int RW   = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int PW   = $clog2(NUM_BANKS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   function automatic logic [BW-1:0] bank_of(input logic [ADDR_W-1:0] a);
      return BW'(a % ADDR_W'(HALF));
   endfunction

   function automatic logic [RW-1:0] row_of(input logic [ADDR_W-1:0] a);
      return RW'(a / ADDR_W'(HALF));
   endfunction

   function automatic logic [PW-1:0] phys_of(input logic region, input logic [BW-1:0] b);
      return PW'(region) * PW'(HALF) + PW'(b);
   endfunction

   state_t                       state, state_nxt;
   logic [RD_LANES*ADDR_W-1:0]   cap_addr;
   logic [RD_LANES-1:0]          pending, pending_nxt, grant, grant_q;
   logic                         release_pend;
   logic                         wr_fire, rd_accept, rel_apply;
   logic [HALF-1:0]              bank_rd_en;
   logic [RW-1:0]                bank_rd_row [HALF];
   logic [DATA_W-1:0]            bank_q [NUM_BANKS];

   assign wr_ready     = !region_full[wr_region];
   assign wr_fire      = wr_valid && wr_ready;
   assign rd_req_ready = (state == IDLE) && region_full[rd_region];
   assign rd_accept    = rd_req_valid && rd_req_ready;

   // A release that arrives with an acceptance is deferred to the end of that read;
   // releases seen while busy are applied on the DRAIN->IDLE edge.
   assign rel_apply = region_full[rd_region] &&
                      (((state == IDLE) && rd_release && !rd_accept) ||
                       ((state == DRAIN) && (rd_release || release_pend)));

   // Per bank, the lowest-index pending lane wins this cycle.
   always_comb begin
      grant      = '0;
      bank_rd_en = '0;
      for (int b = 0; b < HALF; b++) bank_rd_row[b] = '0;
      for (int i = 0; i < RD_LANES; i++) begin
         if ((state == ISSUE) && pending[i] &&
             !bank_rd_en[bank_of(cap_addr[i*ADDR_W +: ADDR_W])]) begin
            grant[i] = 1'b1;
            bank_rd_en[bank_of(cap_addr[i*ADDR_W +: ADDR_W])]  = 1'b1;
            bank_rd_row[bank_of(cap_addr[i*ADDR_W +: ADDR_W])] = row_of(cap_addr[i*ADDR_W +: ADDR_W]);
         end
      end
   end

   assign pending_nxt = pending & ~grant;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_accept) state_nxt = ISSUE;
         ISSUE:   if (pending_nxt == '0) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_full  <= '0;
         wr_region    <= 1'b0;
         rd_region    <= 1'b0;
         release_pend <= 1'b0;
      end else begin
         if (wr_fire && wr_last) region_full[wr_region] <= 1'b1;
         if (rel_apply)          region_full[rd_region] <= 1'b0;
         wr_region <= wr_region ^ (wr_fire && wr_last);
         rd_region <= rd_region ^ rel_apply;
         case (state)
            IDLE:    release_pend <= rd_accept && rd_release;
            ISSUE:   if (rd_release) release_pend <= 1'b1;
            default: release_pend <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_addr     <= '0;
         pending      <= '0;
         grant_q      <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         grant_q  <= grant;
         rd_valid <= (state == DRAIN);
         for (int i = 0; i < RD_LANES; i++) begin
            if (grant_q[i])
               rd_data[i*DATA_W +: DATA_W] <=
                  bank_q[phys_of(rd_region, bank_of(cap_addr[i*ADDR_W +: ADDR_W]))];
         end
         if (rd_accept) begin
            cap_addr <= rd_addr;
            pending  <= rd_lane_en;
            rd_data  <= '0;
         end else if (state == ISSUE) begin
            pending <= pending_nxt;
         end
         if ((state == ISSUE) && (pending_nxt != '0) && (conflict_cnt != 16'hFFFF))
            conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

   // Writer and reader never share a region, so each bank sees at most one access per cycle.
   for (genvar p = 0; p < NUM_BANKS; p++) begin : g_bank
      localparam logic REG = logic'(p / HALF);
      localparam int   LB  = p % HALF;
      logic [DATA_W-1:0] mem [BANK_DEPTH];
      logic [DATA_W-1:0] q;
      logic              we, re;

      assign we = wr_fire && (wr_region == REG) && (bank_of(wr_addr) == BW'(LB));
      assign re = bank_rd_en[LB] && (rd_region == REG);

      always_ff @(posedge clk) begin
         if (we)      mem[row_of(wr_addr)] <= wr_data;
         else if (re) q <= mem[bank_rd_row[LB]];
      end

      assign bank_q[p] = q;
   end

endmodule

// File: tb/tb_imap_pingpong_buf.sv
// Directed bench for imap_pingpong_buf: fills, parallel/conflicting reads, releases, reset mid-read.
module tb_imap_pingpong_buf;

   logic         clk;
   logic         rst_n;
   logic         wr_valid, wr_ready, wr_last;
   logic [11:0]  wr_addr;
   logic [63:0]  wr_data;
   logic         rd_req_valid, rd_req_ready;
   logic [47:0]  rd_addr;
   logic [3:0]   rd_lane_en;
   logic         rd_valid;
   logic [255:0] rd_data;
   logic         rd_release;
   logic [1:0]   region_full;
   logic         wr_region, rd_region;
   logic [15:0]  conflict_cnt;

   int tests = 0;
   int fails = 0;
   int n;
   int seen_valid;

   imap_pingpong_buf dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr), .rd_lane_en(rd_lane_en),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_release(rd_release),
      .region_full(region_full), .wr_region(wr_region), .rd_region(rd_region), .conflict_cnt(conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pack4(input logic [63:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic logic [47:0] addr4(input logic [11:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic fill(input logic [63:0] base);
      for (int a = 0; a < 4096; a++) begin
         wr_valid = 1'b1;
         wr_addr  = 12'(a);
         wr_data  = base + 64'(a);
         wr_last  = (a == 4095);
         tick();
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   // exp_lat = edges after the acceptance edge until rd_valid is seen (ISSUE cycles + 1)
   task automatic do_read(input string tag, input logic [47:0] addrs, input logic [3:0] en,
                          input int exp_lat, input logic [255:0] exp_data);
      chk({tag, "_req_ready"}, 256'(rd_req_ready), 256'd1);
      rd_req_valid = 1'b1;
      rd_addr      = addrs;
      rd_lane_en   = en;
      tick();
      rd_req_valid = 1'b0;
      n = 0;
      while (!rd_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 256'(n), 256'(exp_lat));
      chk({tag, "_data"}, rd_data, exp_data);
      tick();
      chk({tag, "_pulse_end"}, 256'(rd_valid), 256'd0);
      chk({tag, "_data_hold"}, rd_data, exp_data);
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
      rd_req_valid = 1'b0; rd_addr = '0; rd_lane_en = '0; rd_release = 1'b0;
      tick(); tick();
      chk("rst_region_full", 256'(region_full), 256'd0);
      chk("rst_wr_region", 256'(wr_region), 256'd0);
      chk("rst_rd_region", 256'(rd_region), 256'd0);
      chk("rst_rd_valid", 256'(rd_valid), 256'd0);
      chk("rst_rd_data", rd_data, 256'd0);
      chk("rst_conflict", 256'(conflict_cnt), 256'd0);
      chk("rst_wr_ready", 256'(wr_ready), 256'd1);
      chk("rst_req_ready", 256'(rd_req_ready), 256'd0);
      rst_n = 1'b1;
      tick();

      // fill region 0 with data = addr
      fill(64'h0);
      chk("t1_full", 256'(region_full), 256'b01);
      chk("t1_wr_region", 256'(wr_region), 256'd1);
      chk("t1_wr_ready", 256'(wr_ready), 256'd1);

      do_read("t2", addr4(0, 1, 2, 3), 4'hF, 2, pack4(0, 1, 2, 3));
      chk("t2_conflict", 256'(conflict_cnt), 256'd0);

      do_read("t3", addr4(0, 4, 8, 12), 4'hF, 5, pack4(0, 4, 8, 12));
      chk("t3_conflict", 256'(conflict_cnt), 256'd3);

      // lanes 0/1 share bank 1, lanes 2/3 share bank 2 -> two ISSUE cycles
      do_read("pair", addr4(1, 5, 2, 6), 4'hF, 3, pack4(1, 5, 2, 6));
      chk("pair_conflict", 256'(conflict_cnt), 256'd4);

      do_read("lane_mask", addr4(5, 6, 7, 9), 4'b0101, 2, pack4(5, 0, 7, 0));
      do_read("no_lanes", addr4(5, 6, 7, 9), 4'b0000, 2, 256'd0);
      chk("mask_conflict", 256'(conflict_cnt), 256'd4);

      // both regions full, then release region 0
      fill(64'h1000);
      chk("t4_full_both", 256'(region_full), 256'b11);
      chk("t4_wr_ready_lo", 256'(wr_ready), 256'd0);
      chk("t4_wr_region", 256'(wr_region), 256'd0);
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("t4_rel_full", 256'(region_full), 256'b10);
      chk("t4_rel_rd_region", 256'(rd_region), 256'd1);
      chk("t4_rel_wr_ready", 256'(wr_ready), 256'd1);
      do_read("t4_r1", addr4(0, 1, 2, 3), 4'hF, 2, pack4(64'h1000, 64'h1001, 64'h1002, 64'h1003));
      fill(64'h2000);
      chk("t4_refill_full", 256'(region_full), 256'b11);
      chk("t4_refill_wr_region", 256'(wr_region), 256'd1);

      // release during ISSUE is held until the engine returns to IDLE
      chk("t5_req_ready", 256'(rd_req_ready), 256'd1);
      rd_req_valid = 1'b1;
      rd_addr      = addr4(0, 4, 8, 12);
      rd_lane_en   = 4'hF;
      tick();
      rd_req_valid = 1'b0;
      rd_release   = 1'b1;
      tick();
      rd_release   = 1'b0;
      chk("t5_full_held", 256'(region_full), 256'b11);
      n = 1;
      while (!rd_valid && n < 40) begin
         chk("t5_full_while_busy", 256'(region_full), 256'b11);
         tick();
         n++;
      end
      chk("t5_latency", 256'(n), 256'd5);
      chk("t5_full_cleared", 256'(region_full), 256'b01);
      chk("t5_rd_region", 256'(rd_region), 256'd0);
      chk("t5_data", rd_data, pack4(64'h1000, 64'h1004, 64'h1008, 64'h100C));
      chk("t5_conflict", 256'(conflict_cnt), 256'd7);
      tick();
      chk("t5_pulse_end", 256'(rd_valid), 256'd0);

      // refilled region 0 holds the new data
      do_read("t4_r0", addr4(4092, 4093, 4094, 4095), 4'hF, 2,
              pack4(64'h2FFC, 64'h2FFD, 64'h2FFE, 64'h2FFF));

      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("rel_empty_full", 256'(region_full), 256'b00);
      chk("rel_empty_rd_region", 256'(rd_region), 256'd1);
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("rel_ignored_full", 256'(region_full), 256'b00);
      chk("rel_ignored_rd_region", 256'(rd_region), 256'd1);

      // reset while the engine is in DRAIN
      fill(64'h3000);
      chk("t6_full", 256'(region_full), 256'b10);
      chk("t6_req_ready", 256'(rd_req_ready), 256'd1);
      rd_req_valid = 1'b1;
      rd_addr      = addr4(0, 1, 2, 3);
      rd_lane_en   = 4'hF;
      tick();
      rd_req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      seen_valid = 0;
      for (int k = 0; k < 3; k++) begin
         if (rd_valid) seen_valid++;
         tick();
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (rd_valid) seen_valid++;
         tick();
      end
      chk("t6_no_valid", 256'(seen_valid), 256'd0);
      chk("t6_full", 256'(region_full), 256'd0);
      chk("t6_req_ready", 256'(rd_req_ready), 256'd0);
      chk("t6_wr_ready", 256'(wr_ready), 256'd1);
      chk("t6_rd_region", 256'(rd_region), 256'd0);
      chk("t6_wr_region", 256'(wr_region), 256'd0);
      chk("t6_conflict", 256'(conflict_cnt), 256'd0);
      chk("t6_rd_data", rd_data, 256'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
